game_input_conditioner: RTL and testbench

Conditions the raw push-button and slide-switch inputs of the brick-breaker game before they reach the game-logic block. Each input is synchronised, debounced, and converted into the form game logic consumes: a clean level for the run switch, single-cycle press pulses for level-advance and clear, and press pulses with auto-repeat for the paddle keys. Sits directly upstream of the game core; all its outputs are in the CLK domain.

---
 rtl/game_input_conditioner_if.sv | 29 ++
 rtl/game_input_conditioner.sv | 166 ++++++++++++++++
 tb/tb_game_input_conditioner.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/game_input_conditioner_if.sv
// Bundles the raw button/switch inputs and the conditioned outputs of the game input conditioner.
// Latency: none; signal container only.
// Backpressure: none; all outputs are levels or single-cycle pulses.
interface game_input_conditioner_if;
    logic left_raw;
    logic right_raw;
    logic next_raw;
    logic clear_raw;
    logic control_raw;
    logic control;
    logic left_level;
    logic right_level;
    logic left_pulse;
    logic right_pulse;
    logic next_pulse;
    logic clear_pulse;

    // Stimulus side: drives the raw inputs and observes the conditioned outputs.
    modport master (
        output left_raw, right_raw, next_raw, clear_raw, control_raw,
        input  control, left_level, right_level, left_pulse, right_pulse, next_pulse, clear_pulse
    );

    // Conditioner side.
    modport slave (
        input  left_raw, right_raw, next_raw, clear_raw, control_raw,
        output control, left_level, right_level, left_pulse, right_pulse, next_pulse, clear_pulse
    );
endinterface

// File: rtl/game_input_conditioner.sv
// Synchronises, debounces and converts raw buttons/switch into levels, press pulses and paddle auto-repeat.
// Latency: a stable raw level first sampled at edge k appears on outputs at edge k + 2 + DEBOUNCE_CYCLES.
// Backpressure: none; pulses are single-cycle and registered, consumers must sample every cycle.
module game_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 4000000
) (
    input logic                    CLK,
    input logic                    rst_n,
    game_input_conditioner_if.slave io
);
    // Input index map: 0 left, 1 right, 2 next, 3 clear, 4 control.
    localparam int NIN  = 5;
    localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX) + 1;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} paddle_state_t;

    logic [NIN-1:0] raw;
    logic [NIN-1:0] sync1;
    logic [NIN-1:0] sync2;
    logic [NIN-1:0] db;
    logic [NIN-1:0] lvl;
    logic [NIN-1:0] press;
    logic [NIN-1:0] rls;
    logic [DW-1:0]  cnt [NIN];

    paddle_state_t  st_q [2];
    paddle_state_t  st_d [2];
    logic [RW-1:0]  rc_q [2];
    logic [RW-1:0]  rc_d [2];
    logic [1:0]     pad_pulse_d;
    logic [1:0]     pad_pulse_q;
    logic           next_pulse_q;
    logic           clear_pulse_q;

    assign raw = {io.control_raw, io.clear_raw, io.next_raw, io.right_raw, io.left_raw};

    // Edges of the debounced level, taken against its one-cycle-delayed registered copy.
    assign press = db & ~lvl;
    assign rls   = ~db & lvl;

    // Two-flop synchroniser for every raw input.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debouncer: a differing value must persist DEBOUNCE_CYCLES cycles before db follows it.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            db  <= '0;
            lvl <= '0;
            for (int i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            lvl <= db;
            for (int i = 0; i < NIN; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
            end
        end
    end

    // Paddle FSM state and repeat counter registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                st_q[k] <= IDLE;
                rc_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                st_q[k] <= st_d[k];
                rc_q[k] <= rc_d[k];
            end
        end
    end

    // Paddle next-state: the other key's raw debounced level (not the delayed copy) drives the lock,
    // so two presses landing in the same cycle lock each other out.
    always_comb begin
        pad_pulse_d = '0;
        for (int k = 0; k < 2; k++) begin
            st_d[k] = st_q[k];
            rc_d[k] = rc_q[k];
            if (rls[k]) begin
                st_d[k] = IDLE;
                rc_d[k] = '0;
            end else begin
                case (st_q[k])
                    IDLE: begin
                        if (press[k]) begin
                            rc_d[k] = '0;
                            if (db[1-k]) begin
                                st_d[k] = LOCK;
                            end else begin
                                st_d[k]        = DELAY;
                                pad_pulse_d[k] = 1'b1;
                            end
                        end
                    end
                    DELAY: begin
                        if (db[1-k]) begin
                            st_d[k] = LOCK;
                            rc_d[k] = '0;
                        end else if (rc_q[k] == RW'(REPEAT_DELAY - 1)) begin
                            st_d[k]        = REPEAT;
                            rc_d[k]        = '0;
                            pad_pulse_d[k] = 1'b1;
                        end else begin
                            rc_d[k] = rc_q[k] + RW'(1);
                        end
                    end
                    REPEAT: begin
                        if (db[1-k]) begin
                            st_d[k] = LOCK;
                            rc_d[k] = '0;
                        end else if (rc_q[k] == RW'(REPEAT_RATE - 1)) begin
                            rc_d[k]        = '0;
                            pad_pulse_d[k] = 1'b1;
                        end else begin
                            rc_d[k] = rc_q[k] + RW'(1);
                        end
                    end
                    default: begin
                        rc_d[k] = '0;
                    end
                endcase
            end
        end
    end

    // Registered pulse outputs; clear takes priority over a simultaneous next press.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pad_pulse_q   <= '0;
            next_pulse_q  <= 1'b0;
            clear_pulse_q <= 1'b0;
        end else begin
            pad_pulse_q   <= pad_pulse_d;
            next_pulse_q  <= press[2] & ~press[3];
            clear_pulse_q <= press[3];
        end
    end

    assign io.left_level  = lvl[0];
    assign io.right_level = lvl[1];
    assign io.control     = lvl[4];
    assign io.left_pulse  = pad_pulse_q[0];
    assign io.right_pulse = pad_pulse_q[1];
    assign io.next_pulse  = next_pulse_q;
    assign io.clear_pulse = clear_pulse_q;
endmodule

// File: tb/tb_game_input_conditioner.sv
// Directed self-checking bench for the game input conditioner with short debounce/repeat parameters.
// Latency: expected outputs at 2 + DEBOUNCE_CYCLES edges after the first raw sample.
// Backpressure: none; outputs are sampled 1 ns after every rising edge.
module tb_game_input_conditioner;
    logic CLK;
    logic rst_n;
    int   checks;
    int   failures;
    int   cnt_a;
    int   cnt_b;
    int   pos;
    int   lp[$];

    game_input_conditioner_if io();

    game_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (8)
    ) dut (
        .CLK  (CLK),
        .rst_n(rst_n),
        .io   (io)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, io.control, io.left_level, io.right_level, io.left_pulse,
                io.right_pulse, io.next_pulse, io.clear_pulse};
    endfunction

    function automatic int at(input int j);
        return (lp.size() > j) ? lp[j] : -1;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        // Reset with every raw input high.
        rst_n = 1'b0;
        io.left_raw = 1'b1; io.right_raw = 1'b1; io.next_raw = 1'b1;
        io.clear_raw = 1'b1; io.control_raw = 1'b1;
        step(3);
        chk("reset_outputs", outs(), 32'd0);
        rst_n = 1'b1;
        step(6);
        chk("rst_release_level_early", io.left_level, 1'b0);
        step(1);
        chk("rst_release_left_level", io.left_level, 1'b1);
        chk("rst_release_control", io.control, 1'b1);
        chk("rst_release_clear_pulse", io.clear_pulse, 1'b1);
        chk("rst_release_next_pulse", io.next_pulse, 1'b0);
        chk("rst_release_left_pulse_locked", io.left_pulse, 1'b0);
        step(1);
        chk("rst_release_clear_one_cycle", io.clear_pulse, 1'b0);
        io.left_raw = 1'b0; io.right_raw = 1'b0; io.next_raw = 1'b0;
        io.clear_raw = 1'b0; io.control_raw = 1'b0;
        step(12);
        chk("all_released", outs(), 32'd0);

        // Bounce on next_raw, then a clean hold.
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            io.next_raw = (i % 2 == 0);
            repeat (2) begin
                step(1);
                cnt_a += int'(io.next_pulse);
            end
        end
        io.next_raw = 1'b1;
        pos = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (io.next_pulse) begin
                cnt_a++;
                if (pos < 0) pos = i;
            end
        end
        chk("bounce_pulse_count", cnt_a, 32'd1);
        chk("bounce_pulse_position", pos, 32'd7);
        io.next_raw = 1'b0;
        cnt_b = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            cnt_b += int'(io.next_pulse);
        end
        chk("bounce_release_no_pulse", cnt_b, 32'd0);

        // Auto-repeat on the right key.
        lp.delete();
        io.right_raw = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            if (i == 60) io.right_raw = 1'b0;
            step(1);
            if (io.right_pulse) lp.push_back(i);
        end
        chk("repeat_count", lp.size(), 32'd6);
        chk("repeat_p0", at(0), 32'd7);
        chk("repeat_p1", at(1), 32'd27);
        chk("repeat_p2", at(2), 32'd35);
        chk("repeat_p3", at(3), 32'd43);
        chk("repeat_p4", at(4), 32'd51);
        chk("repeat_p5", at(5), 32'd59);
        chk("repeat_level_released", io.right_level, 1'b0);

        // Lock: right pressed while left is held.
        lp.delete();
        cnt_b = 0;
        io.left_raw = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            if (i == 11) io.right_raw = 1'b1;
            if (i == 31) io.right_raw = 1'b0;
            step(1);
            if (io.left_pulse) lp.push_back(i);
            cnt_b += int'(io.right_pulse);
        end
        chk("lock_left_count", lp.size(), 32'd1);
        chk("lock_left_p0", at(0), 32'd7);
        chk("lock_right_silent", cnt_b, 32'd0);
        io.left_raw = 1'b0;
        step(12);
        io.left_raw = 1'b1;
        step(6);
        chk("repress_pulse_early", io.left_pulse, 1'b0);
        step(1);
        chk("repress_pulse", io.left_pulse, 1'b1);
        step(20);
        chk("repress_first_repeat", io.left_pulse, 1'b1);

        // Asynchronous reset while left is in REPEAT with a pulse on the output.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_left_pulse", io.left_pulse, 1'b0);
        chk("async_rst_left_level", io.left_level, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(6);
        chk("post_rst_level_early", io.left_level, 1'b0);
        step(1);
        chk("post_rst_idle_press_pulse", io.left_pulse, 1'b1);
        chk("post_rst_left_level", io.left_level, 1'b1);
        step(1);
        chk("post_rst_pulse_one_cycle", io.left_pulse, 1'b0);
        io.left_raw = 1'b0;
        step(12);

        // Simultaneous clear and next presses.
        cnt_a = 0;
        cnt_b = 0;
        pos   = -1;
        io.clear_raw = 1'b1;
        io.next_raw  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (io.clear_pulse) begin
                cnt_a++;
                if (pos < 0) pos = i;
            end
            cnt_b += int'(io.next_pulse);
        end
        chk("simul_clear_count", cnt_a, 32'd1);
        chk("simul_clear_position", pos, 32'd7);
        chk("simul_next_count", cnt_b, 32'd0);
        io.clear_raw = 1'b0;
        io.next_raw  = 1'b0;
        step(12);
        chk("final_outputs_idle", outs(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
